// File: rtl/scan_pkg.sv
// Shared types and constants for the BCD digit scanner.
// Holds the FSM state encoding and the BCD sanitising helper.
package scan_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } scan_state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BLANK_CODE = 4'b0000;

    // Codes above 9 are replaced so the display never sees them.
    function automatic logic [3:0] bcd_clean(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BLANK_CODE : nib;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-period prescaler: counts 0..PRESCALE-1 while enabled.
// tick is high during the last count, i.e. on the advancing edge.
module scan_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold at zero when disabled, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Multiplexed BCD display scanner with frame-synchronous reload.
// New data is shadowed and swapped in only at the frame wrap.
module bcd_digit_scanner
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              dig_bcd,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    scan_tick,
    output logic                    bcd_err
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    tick_q;

    logic                    accept;
    logic                    adv;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] clean;
    logic                    bad;

    scan_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ST_SCAN),
        .tick(adv)
    );

    // Sanitise the offered word and flag any out-of-range nibble.
    always_comb begin
        clean = '0;
        bad   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clean[i*4 +: 4] = bcd_clean(load_data[i*4 +: 4]);
            if (load_data[i*4 +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end
        end
    end

    assign accept = load_valid && ready_q;
    assign wrap   = adv && (idx_q == IDX_LAST);

    // Next-state logic for FSM, digit index and data registers.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        err_d     = err_q;
        unique case (state_q)
            ST_BLANK: begin
                if (accept) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    disp_d  = clean;
                    err_d   = err_q | bad;
                end
            end
            ST_SCAN: begin
                if (adv) begin
                    idx_d = wrap ? '0 : idx_q + IW'(1);
                end
                if (wrap && pending_q) begin
                    disp_d    = shadow_q;
                    pending_d = 1'b0;
                end
                // accept implies pending_q was clear, so a wrap-edge
                // accept simply waits for the following boundary.
                if (accept) begin
                    shadow_d  = clean;
                    pending_d = 1'b1;
                    err_d     = err_q | bad;
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase
        ready_d = !pending_d;
    end

    // Output decode from next-state values so outputs move with idx.
    always_comb begin
        sel_d = '0;
        bcd_d = BLANK_CODE;
        if (state_d == ST_SCAN) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IW'(i) == idx_d) begin
                    sel_d[i] = 1'b1;
                    bcd_d    = disp_d[i*4 +: 4];
                end
            end
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BLANK;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            sel_q     <= '0;
            bcd_q     <= BLANK_CODE;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            sel_q     <= sel_d;
            bcd_q     <= bcd_d;
            tick_q    <= adv;
        end
    end

    assign load_ready = ready_q;
    assign dig_sel    = sel_q;
    assign dig_bcd    = bcd_q;
    assign scan_tick  = tick_q;
    assign bcd_err    = err_q;

endmodule
